uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 40 ++++
 rtl/uart_rx_fifo_mem_1r1w.sv | 27 ++
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared register map, CTRL field positions and word layouts for the UART receive FIFO.
package uart_rx_fifo_pkg;

    localparam logic [1:0] UARTFIFO_DATA   = 2'd0;
    localparam logic [1:0] UARTFIFO_STATUS = 2'd1;
    localparam logic [1:0] UARTFIFO_CTRL   = 2'd2;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;
    localparam int unsigned CTRL_RX_IEN_BIT  = 2;
    localparam int unsigned CTRL_OVF_IEN_BIT = 3;
    localparam int unsigned CTRL_THRESH_LSB  = 8;
    localparam int unsigned CTRL_THRESH_W    = 8;

    // STATUS read word
    typedef struct packed {
        logic        overflow;
        logic        full;
        logic        empty;
        logic [12:0] rsvd;
        logic [15:0] count;
    } status_word_t;

    // CTRL read word; the write-only strobes always read back as zero
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  thresh;
        logic [3:0]  rsvd_mid;
        logic        ovf_ien;
        logic        rx_ien;
        logic        clr_ovf;
        logic        flush;
    } ctrl_word_t;

    // A programmed threshold of zero behaves as one
    function automatic logic [7:0] thresh_eff(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem_1r1w.sv
// Storage array: synchronous write, asynchronous read, no reset on contents.
module fifo_mem_1r1w #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with MMIO register window and level interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  THRESH_RST = 8'd1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxnew,
    input  logic [7:0]  rxdata,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        irq
);

    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(1 << DEPTH_LOG2);

    logic [PTR_W-1:0] head, tail, head_nx, tail_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             overflow, ovf_nx;
    logic             rx_ien, rx_ien_nx;
    logic             ovf_ien, ovf_ien_nx;
    logic [7:0]       thresh, thresh_nx;
    logic             irq_nx;
    logic             rd_q;
    logic [7:0]       head_byte;

    logic empty, full, ctrl_wr, flush, clr_ovf, pop, push, ovf_set;
    logic unused_d;

    assign unused_d = ^{d[31:16], d[7:4]};

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign ctrl_wr = we && (a == UARTFIFO_CTRL);
    assign flush   = ctrl_wr && d[CTRL_FLUSH_BIT];
    assign clr_ovf = ctrl_wr && d[CTRL_CLR_OVF_BIT];
    assign pop     = rd && !rd_q && (a == UARTFIFO_DATA) && !empty;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign push    = rxnew && (!full || pop) && !flush;
    assign ovf_set = rxnew && full && !pop;

    fifo_mem_1r1w #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .wr_en (push),
        .waddr (tail),
        .wdata (rxdata),
        .raddr (head),
        .rdata (head_byte)
    );

    // Next-state for pointers, count, sticky overflow, control fields and irq
    always_comb begin
        head_nx    = head;
        tail_nx    = tail;
        count_nx   = count;
        ovf_nx     = overflow;
        rx_ien_nx  = rx_ien;
        ovf_ien_nx = ovf_ien;
        thresh_nx  = thresh;

        if (flush) begin
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
        end else begin
            if (pop)  head_nx = head + PTR_W'(1);
            if (push) tail_nx = tail + PTR_W'(1);
            if (push && !pop)      count_nx = count + CNT_W'(1);
            else if (pop && !push) count_nx = count - CNT_W'(1);
        end

        // A same-cycle overflow outranks the clear request
        if (clr_ovf) ovf_nx = 1'b0;
        if (ovf_set) ovf_nx = 1'b1;

        if (ctrl_wr) begin
            rx_ien_nx  = d[CTRL_RX_IEN_BIT];
            ovf_ien_nx = d[CTRL_OVF_IEN_BIT];
            thresh_nx  = d[CTRL_THRESH_LSB +: CTRL_THRESH_W];
        end

        irq_nx = (rx_ien_nx && (count_nx != '0) && (8'(count_nx) >= thresh_eff(thresh_nx)))
               || (ovf_ien_nx && ovf_nx);
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rx_ien   <= 1'b0;
            ovf_ien  <= 1'b0;
            thresh   <= THRESH_RST;
            irq      <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            head     <= head_nx;
            tail     <= tail_nx;
            count    <= count_nx;
            overflow <= ovf_nx;
            rx_ien   <= rx_ien_nx;
            ovf_ien  <= ovf_ien_nx;
            thresh   <= thresh_nx;
            irq      <= irq_nx;
            rd_q     <= rd;
        end
    end

    // Register read mux
    always_comb begin
        status_word_t st;
        ctrl_word_t   ct;
        st          = '0;
        st.overflow = overflow;
        st.full     = full;
        st.empty    = empty;
        st.count    = 16'(count);
        ct          = '0;
        ct.thresh   = thresh;
        ct.ovf_ien  = ovf_ien;
        ct.rx_ien   = rx_ien;
        spo         = '0;
        case (a)
            UARTFIFO_DATA:   spo = {empty, 23'b0, (empty ? 8'h00 : head_byte)};
            UARTFIFO_STATUS: spo = st;
            UARTFIFO_CTRL:   spo = ct;
            default:         spo = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized phase against a queue model.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rstn;
    logic        rxnew;
    logic [7:0]  rxdata;
    logic [1:0]  a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_rien;
    bit         m_oien;
    logic [7:0] m_thr;

    uart_rx_fifo #(.DEPTH_LOG2(4), .THRESH_RST(8'd1)) dut (
        .clk(clk), .rstn(rstn), .rxnew(rxnew), .rxdata(rxdata), .a(a),
        .d(d), .we(we), .rd(rd), .spo(spo), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf = 0; m_rien = 0; m_oien = 0; m_thr = 8'd1;
    endfunction

    function automatic logic [31:0] exp_data();
        return (q.size() == 0) ? 32'h8000_0000 : {24'h0, q[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        return {m_ovf, q.size() == DEPTH, q.size() == 0, 13'b0, 16'(q.size())};
    endfunction

    function automatic logic [31:0] exp_ctrl();
        return {16'b0, m_thr, 4'b0, m_oien, m_rien, 2'b0};
    endfunction

    function automatic logic exp_irq();
        int eff;
        eff = (m_thr == 0) ? 1 : int'(m_thr);
        return (m_rien && q.size() > 0 && q.size() >= eff) || (m_oien && m_ovf);
    endfunction

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = spo;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        rd_reg(UARTFIFO_STATUS, v); check({tag, ".status"}, v, exp_status());
        rd_reg(UARTFIFO_CTRL, v);   check({tag, ".ctrl"}, v, exp_ctrl());
        rd_reg(UARTFIFO_DATA, v);   check({tag, ".data"}, v, exp_data());
        rd_reg(2'd3, v);            check({tag, ".reg3"}, v, 32'h0);
        check({tag, ".irq"}, {31'b0, irq}, {31'b0, exp_irq()});
    endtask

    // One cycle of optional push and optional rd rising edge at DATA
    task automatic step(input bit do_push, input logic [7:0] b, input bit do_pop);
        logic [31:0] pre;
        bit was_full, popped;
        pre = exp_data();
        a = UARTFIFO_DATA; rd = do_pop; rxnew = do_push; rxdata = b;
        #1;
        if (do_pop) check("pop_prehead", spo, pre);
        was_full = (q.size() == DEPTH);
        popped   = do_pop && (q.size() > 0);
        if (popped) void'(q.pop_front());
        if (do_push) begin
            if (!was_full || popped) q.push_back(b);
            else m_ovf = 1;
        end
        tick();
        rd = 0; rxnew = 0;
        if (do_pop) tick();
    endtask

    task automatic wr_ctrl(input logic [31:0] v, input bit do_push, input logic [7:0] b);
        bit was_full;
        was_full = (q.size() == DEPTH);
        a = UARTFIFO_CTRL; we = 1; d = v; rxnew = do_push; rxdata = b;
        tick();
        we = 0; rxnew = 0; d = 0;
        if (v[0]) q.delete();
        else if (do_push && !was_full) q.push_back(b);
        if (v[1]) m_ovf = 0;
        if (do_push && was_full) m_ovf = 1;
        m_rien = v[2]; m_oien = v[3]; m_thr = v[15:8];
    endtask

    initial begin
        logic [31:0] v;
        rstn = 0; rxnew = 0; rxdata = 0; a = 0; d = 0; we = 0; rd = 0;
        model_reset();
        repeat (3) tick();
        rstn = 1;
        tick();

        // Reset state
        rd_reg(UARTFIFO_STATUS, v); check("rst.status", v, 32'h2000_0000);
        rd_reg(UARTFIFO_CTRL, v);   check("rst.ctrl", v, 32'h0000_0100);
        rd_reg(UARTFIFO_DATA, v);   check("rst.data", v, 32'h8000_0000);
        check("rst.irq", {31'b0, irq}, 32'h0);

        // Three bytes popped in order
        step(1, 8'h41, 0); step(1, 8'h42, 0); step(1, 8'h43, 0);
        rd_reg(UARTFIFO_DATA, v); check("order.0", v, 32'h0000_0041);
        step(0, 0, 1);
        rd_reg(UARTFIFO_DATA, v); check("order.1", v, 32'h0000_0042);
        step(0, 0, 1);
        rd_reg(UARTFIFO_DATA, v); check("order.2", v, 32'h0000_0043);
        step(0, 0, 1);
        rd_reg(UARTFIFO_STATUS, v); check("order.empty", v, 32'h2000_0000);
        rd_reg(UARTFIFO_DATA, v);   check("order.data_empty", v, 32'h8000_0000);

        // Held rd pops exactly once
        step(1, 8'h11, 0); step(1, 8'h22, 0);
        a = UARTFIFO_DATA; rd = 1;
        void'(q.pop_front());
        for (int i = 0; i < 5; i++) begin
            tick();
            rd_reg(UARTFIFO_STATUS, v); check("hold.count", {16'b0, v[15:0]}, 32'd1);
            a = UARTFIFO_DATA;
        end
        rd = 0; tick();
        check_all("hold");

        // Seventeen pushes: full, overflow, wrap
        wr_ctrl(32'h0000_0101, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 8'(i), 0);
        rd_reg(UARTFIFO_STATUS, v); check("ovf.status", v, 32'hC000_0010);
        for (int i = 0; i < 16; i++) begin
            rd_reg(UARTFIFO_DATA, v); check("wrap.data", v, 32'(i));
            step(0, 0, 1);
        end
        check_all("wrap");
        wr_ctrl(32'h0000_0002, 0, 0);
        rd_reg(UARTFIFO_STATUS, v); check("ovf.clear", v, 32'h2000_0000);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0);
        step(1, 8'hA5, 1);
        rd_reg(UARTFIFO_STATUS, v); check("fullpop.status", v, 32'h4000_0010);
        for (int i = 0; i < 15; i++) step(0, 0, 1);
        rd_reg(UARTFIFO_DATA, v); check("fullpop.last", v, 32'h0000_00A5);
        step(0, 0, 1);
        check_all("fullpop");

        // Clear overflow loses to a same-cycle overflowing push
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'hEE, 0);
        wr_ctrl(32'h0000_0002, 1, 8'h99);
        rd_reg(UARTFIFO_STATUS, v); check("setwins.ovf", {31'b0, v[31]}, 32'h1);
        wr_ctrl(32'h0000_0003, 0, 0);
        check_all("setwins");

        // Threshold interrupt
        wr_ctrl(32'h0000_0304, 0, 0);
        step(1, 8'h01, 0); check("thr.irq1", {31'b0, irq}, 32'h0);
        step(1, 8'h02, 0); check("thr.irq2", {31'b0, irq}, 32'h0);
        step(1, 8'h03, 0); check("thr.irq3", {31'b0, irq}, 32'h1);
        a = UARTFIFO_DATA; rd = 1; tick(); rd = 0;
        void'(q.pop_front());
        check("thr.irq_pop", {31'b0, irq}, 32'h0);
        tick();
        check_all("thr");

        // Flush wins over a same-cycle push
        wr_ctrl(32'h0000_0305, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0);
        check("flush.pre_irq", {31'b0, irq}, 32'h1);
        wr_ctrl(32'h0000_0001, 1, 8'h77);
        rd_reg(UARTFIFO_STATUS, v); check("flush.status", v, 32'h2000_0000);
        check("flush.irq", {31'b0, irq}, 32'h0);
        check_all("flush");

        // Writes to non-CTRL addresses are ignored
        step(1, 8'h5A, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) continue;
            a = 2'(i); we = 1; d = 32'hFFFF_FFFF; tick(); we = 0;
        end
        check_all("ignored");

        // Randomized traffic against the queue model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45) step(1, 8'($urandom), 0);
            else if (r < 72) step(0, 0, 1);
            else if (r < 82) step(1, 8'($urandom), 1);
            else if (r < 90) begin
                logic [31:0] cv;
                bit fl;
                fl = ($urandom_range(0, 3) == 0);
                cv = {16'b0, 8'($urandom_range(0, 18)), 4'b0,
                      1'($urandom), 1'($urandom), 1'($urandom), fl};
                wr_ctrl(cv, !fl && ($urandom_range(0, 1) == 1), 8'($urandom));
            end else if (r < 95) begin
                a = 2'($urandom_range(0, 1)); if ($urandom_range(0, 1) == 1) a = 2'd3;
                we = 1; d = $urandom; tick(); we = 0;
            end else step(0, 0, 0);
            check_all("rand");
        end

        // Asynchronous reset in the middle of a burst
        wr_ctrl(32'h0000_010D, 0, 0);
        step(1, 8'hC1, 0); step(1, 8'hC2, 0); step(1, 8'hC3, 0);
        check("arst.pre_irq", {31'b0, irq}, 32'h1);
        rxnew = 1; rxdata = 8'h55; a = UARTFIFO_DATA; rd = 1;
        #3;
        rstn = 0;
        #1;
        check("arst.irq", {31'b0, irq}, 32'h0);
        rd_reg(UARTFIFO_DATA, v);   check("arst.data", v, 32'h8000_0000);
        rd_reg(UARTFIFO_STATUS, v); check("arst.status", v, 32'h2000_0000);
        rd_reg(UARTFIFO_CTRL, v);   check("arst.ctrl", v, 32'h0000_0100);
        rxnew = 0; rd = 0;
        model_reset();
        tick();
        rstn = 1;
        tick();
        check_all("arst_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
